mdl: RTL and testbench
======================

MDL -- requirements
Module: mdl

Interface
REQ-001 Parameter WIDTH, default 8, data word width in bits.
REQ-002 Parameter NUM_KERNEL, default 8, number of kernel words (2..256).
REQ-003 Parameter AW, default 3, address width; SHALL satisfy 2**AW >= NUM_KERNEL.
REQ-004 clk  input  1  rising-edge clock; the single clock of the block.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 op  input  3  opcode: 000 NOP, 001 SHIFTRIGHT2, 010 WRITE, 011 READ, 100 CLEAR; 101-111 treated as NOP.
REQ-007 op_valid  input  1  request strobe; a request is accepted on a clk edge when op_valid=1 and op_ready=1.
REQ-008 addr  input  AW  target word index.
REQ-009 din  input  WIDTH  write data.
REQ-010 op_ready  output  1  block can accept a request this cycle.
REQ-011 dout  output  WIDTH  registered read data.
REQ-012 dout_valid  output  1  one-cycle pulse qualifying dout.
REQ-013 busy  output  1  CLEAR sweep in progress.
REQ-014 err  output  1  one-cycle pulse: accepted request had addr >= NUM_KERNEL.
REQ-015 Ports SHALL be declared in the order listed, so positional instances with leading ports only elaborate.

Function
REQ-016 Storage: NUM_KERNEL registers Kernel[0..NUM_KERNEL-1], each WIDTH bits.
REQ-017 op_ready SHALL equal ~busy (combinational).
REQ-018 WRITE: Kernel[addr] <= din at the accepting edge; new value readable by a READ accepted on the next cycle.
REQ-019 READ: dout <= Kernel[addr] and dout_valid=1 for exactly one cycle after the accepting edge (latency 1); otherwise dout holds its last value and dout_valid=0.
REQ-020 SHIFTRIGHT2: Kernel[addr] <= Kernel[addr] >> 2, zero-filled MSBs, at the accepting edge.
REQ-021 CLEAR: busy=1 from the cycle after acceptance for exactly NUM_KERNEL cycles; an internal pointer ProgCntr walks 0..NUM_KERNEL-1, zeroing Kernel[ProgCntr] each cycle; busy drops on the cycle after the last word is cleared; addr is ignored for CLEAR.
REQ-022 While busy=1, op_valid is ignored (no acceptance, no err, no side effects).
REQ-023 Address out of range (addr >= NUM_KERNEL) on WRITE/READ/SHIFTRIGHT2: no storage change, no dout_valid, err=1 for one cycle after the accepting edge.
REQ-024 NOP and opcodes 101-111: accepted with no effect, no err.
REQ-025 Exactly one request is processed per accepted edge; back-to-back requests on consecutive cycles SHALL each complete with the latencies above.
REQ-026 ProgCntr SHALL not wrap past NUM_KERNEL-1; it returns to 0 when the sweep ends.

Reset
REQ-027 rst=1 asynchronously clears all Kernel words to 0, dout=0, dout_valid=0, err=0, busy=0, ProgCntr=0; op_ready=1 while rst=1 is deasserted-idle.
REQ-028 rst asserted mid-CLEAR aborts the sweep immediately; all words are 0 and busy=0 on release.
REQ-029 No request is accepted on any edge where rst=1.

Verification
REQ-030 After reset, READ addr 0..7 -> dout=8'h00, dout_valid pulses one cycle after each accept.
REQ-031 WRITE addr 3 din 8'hB4, then READ addr 3 -> dout=8'hB4 one cycle after READ accepted.
REQ-032 WRITE addr 5 din 8'hFF, SHIFTRIGHT2 addr 5, READ addr 5 -> dout=8'h3F.
REQ-033 Fill all words with 8'hA5, CLEAR -> busy high exactly 8 cycles, op_ready low throughout, op_valid during busy ignored; then all READs return 8'h00.
REQ-034 With NUM_KERNEL=6, WRITE addr 7 -> err pulses one cycle, no word changes, dout_valid stays 0.
REQ-035 Assert rst on the 3rd busy cycle of a CLEAR -> busy=0, op_ready=1, dout=0 immediately without a clk edge.

Source files
------------

// File: rtl/mdl.sv
// Kernel register file with per-word write, read, shift-right-by-two and a
// multi-cycle clear sweep that stalls the request interface while it runs.
module mdl #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned NUM_KERNEL = 8,
  parameter int unsigned AW         = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       op,
  input  logic             op_valid,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] din,
  output logic             op_ready,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  output logic             busy,
  output logic             err
);

  localparam int unsigned NK = NUM_KERNEL;
  localparam int unsigned IW = (NK > 1) ? $clog2(NK) : 1;

  localparam logic [2:0] OP_SHR2  = 3'b001;
  localparam logic [2:0] OP_WRITE = 3'b010;
  localparam logic [2:0] OP_READ  = 3'b011;
  localparam logic [2:0] OP_CLEAR = 3'b100;

  typedef enum logic {ST_IDLE, ST_CLEAR} state_e;

  state_e           state_q, state_d;
  logic [IW-1:0]    pc_q, pc_d;
  logic [WIDTH-1:0] kernel [NK];
  logic             accept;
  logic             in_range;
  logic             word_op;
  logic [IW-1:0]    idx;

  assign op_ready = ~busy;
  assign accept   = op_valid & op_ready;
  assign in_range = 32'(addr) < NK;
  assign word_op  = (op == OP_WRITE) || (op == OP_READ) || (op == OP_SHR2);
  assign idx      = IW'(addr);

  // State and sweep-pointer registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy    <= (state_d == ST_CLEAR);
    end
  end

  // Next state: the pointer stops at the last word and returns to zero
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      ST_IDLE: begin
        if (accept && (op == OP_CLEAR)) begin
          state_d = ST_CLEAR;
          pc_d    = '0;
        end
      end
      ST_CLEAR: begin
        if (pc_q == IW'(NK - 1)) begin
          state_d = ST_IDLE;
          pc_d    = '0;
        end else begin
          pc_d = pc_q + IW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Storage and response datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < int'(NK); k++) kernel[k] <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      dout_valid <= 1'b0;
      err        <= 1'b0;
      if (state_q == ST_CLEAR) begin
        kernel[pc_q] <= '0;
      end else if (accept) begin
        if (word_op && !in_range) begin
          err <= 1'b1;
        end else begin
          case (op)
            OP_WRITE: kernel[idx] <= din;
            OP_READ: begin
              dout       <= kernel[idx];
              dout_valid <= 1'b1;
            end
            OP_SHR2: kernel[idx] <= kernel[idx] >> 2;
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mdl.sv
// Bench for mdl: an 8-word and a 6-word instance share one stimulus stream and
// are checked every cycle against a word-array reference model.
module tb_mdl;

  localparam logic [2:0] NOP = 3'b000, SHR2 = 3'b001, WR = 3'b010,
                         RD = 3'b011, CLR = 3'b100;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] op;
  logic       op_valid;
  logic [2:0] addr;
  logic [7:0] din;

  logic       rdy8, dv8, busy8, err8;
  logic [7:0] dout8;
  logic       rdy6, dv6, busy6, err6;
  logic [7:0] dout6;

  int total = 0;
  int bad   = 0;

  // reference state: index 0 -> 8-word instance, index 1 -> 6-word instance
  int         nk [2] = '{8, 6};
  logic [7:0] mk [2][8];
  logic [7:0] mdout [2];
  bit         mdv [2];
  bit         merr [2];
  int         remaining [2];

  mdl #(.WIDTH(8), .NUM_KERNEL(8), .AW(3)) dut8 (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .addr(addr), .din(din),
    .op_ready(rdy8), .dout(dout8), .dout_valid(dv8), .busy(busy8), .err(err8)
  );

  mdl #(.WIDTH(8), .NUM_KERNEL(6), .AW(3)) dut6 (
    .clk(clk), .rst(rst), .op(op), .op_valid(op_valid), .addr(addr), .din(din),
    .op_ready(rdy6), .dout(dout6), .dout_valid(dv6), .busy(busy6), .err(err6)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      for (int j = 0; j < 8; j++) mk[i][j] = 8'h00;
      mdout[i]     = 8'h00;
      mdv[i]       = 1'b0;
      merr[i]      = 1'b0;
      remaining[i] = 0;
    end
  endtask

  // One clock edge of behaviour, from the request currently on the inputs
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      mdv[i]  = 1'b0;
      merr[i] = 1'b0;
      if (remaining[i] > 0) begin
        mk[i][nk[i] - remaining[i]] = 8'h00;
        remaining[i]--;
      end else if (op_valid) begin
        if ((op == WR || op == RD || op == SHR2) && int'(addr) >= nk[i]) begin
          merr[i] = 1'b1;
        end else begin
          case (op)
            WR:   mk[i][addr] = din;
            RD:   begin mdout[i] = mk[i][addr]; mdv[i] = 1'b1; end
            SHR2: mk[i][addr] = mk[i][addr] / 4;
            CLR:  remaining[i] = nk[i];
            default: ;
          endcase
        end
      end
    end
  endtask

  task automatic check_all();
    check("k8_dout",  32'(dout8), 32'(mdout[0]));
    check("k8_dv",    32'(dv8),   32'(mdv[0]));
    check("k8_err",   32'(err8),  32'(merr[0]));
    check("k8_busy",  32'(busy8), 32'(remaining[0] > 0));
    check("k8_ready", 32'(rdy8),  32'(remaining[0] == 0));
    check("k6_dout",  32'(dout6), 32'(mdout[1]));
    check("k6_dv",    32'(dv6),   32'(mdv[1]));
    check("k6_err",   32'(err6),  32'(merr[1]));
    check("k6_busy",  32'(busy6), 32'(remaining[1] > 0));
    check("k6_ready", 32'(rdy6),  32'(remaining[1] == 0));
  endtask

  task automatic step(input logic [2:0] o, input logic v, input logic [2:0] a, input logic [7:0] d);
    @(negedge clk);
    op = o; op_valid = v; addr = a; din = d;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt8, cnt6;
    int r;
    logic [2:0] o;
    op = NOP; op_valid = 1'b0; addr = '0; din = '0; rst = 1'b0;
    #1 rst = 1'b1;
    model_reset();
    // a request held during reset must not land
    op = WR; op_valid = 1'b1; addr = 3'd1; din = 8'h77;
    repeat (2) @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0; op_valid = 1'b0;

    for (int a = 0; a < 8; a++) step(RD, 1'b1, 3'(a), 8'h00);

    step(WR, 1'b1, 3'd3, 8'hB4);
    step(RD, 1'b1, 3'd3, 8'h00);
    check("rd3_b4", 32'(dout8), 32'h0B4);

    step(WR, 1'b1, 3'd5, 8'hFF);
    step(SHR2, 1'b1, 3'd5, 8'h00);
    step(RD, 1'b1, 3'd5, 8'h00);
    check("shr2_3f", 32'(dout8), 32'h03F);

    // fill, then clear with requests offered while the sweep runs
    for (int a = 0; a < 8; a++) step(WR, 1'b1, 3'(a), 8'hA5);
    step(CLR, 1'b1, 3'd2, 8'h00);
    cnt8 = int'(busy8);
    cnt6 = int'(busy6);
    for (int j = 0; j < 10; j++) begin
      step(WR, busy8, 3'(j), 8'h5A);
      cnt8 += int'(busy8);
      cnt6 += int'(busy6);
    end
    check("clr_busy8_cycles", 32'(cnt8), 32'd8);
    check("clr_busy6_cycles", 32'(cnt6), 32'd6);
    for (int a = 0; a < 8; a++) begin
      step(RD, 1'b1, 3'(a), 8'h00);
      check("clr_rd_zero", 32'(dout8), 32'h0);
    end

    step(WR, 1'b1, 3'd7, 8'h11);
    check("oor_err6", 32'(err6), 32'd1);
    check("oor_dv6", 32'(dv6), 32'd0);
    for (int a = 0; a < 6; a++) step(RD, 1'b1, 3'(a), 8'h00);

    // reset asserted in the third busy cycle of a sweep
    for (int a = 0; a < 8; a++) step(WR, 1'b1, 3'(a), 8'(8'h30 + a));
    step(RD, 1'b1, 3'd4, 8'h00);
    step(CLR, 1'b1, 3'd0, 8'h00);
    step(NOP, 1'b0, 3'd0, 8'h00);
    step(NOP, 1'b0, 3'd0, 8'h00);
    check("pre_rst_busy", 32'(busy8), 32'd1);
    #2 rst = 1'b1;
    model_reset();
    #1 check_all();
    check("rst_async_dout", 32'(dout8), 32'h0);
    op = WR; op_valid = 1'b1; addr = 3'd6; din = 8'hEE;
    @(posedge clk);
    #1 check_all();
    @(negedge clk) rst = 1'b0; op_valid = 1'b0;
    for (int a = 0; a < 8; a++) step(RD, 1'b1, 3'(a), 8'h00);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      r = int'($urandom_range(0, 31));
      if (r == 0)       o = CLR;
      else if (r < 11)  o = WR;
      else if (r < 20)  o = RD;
      else if (r < 26)  o = SHR2;
      else if (r < 28)  o = NOP;
      else              o = 3'(5 + ($urandom % 3));
      step(o, 1'(($urandom % 4) != 0), 3'($urandom % 8), 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
